// File: rtl/fbcpu_pkg.sv
// fbcpu_pkg: shared widths, opcodes and boot-loader state encoding for the FBCPU.
package fbcpu_pkg;
  localparam int ADDRESS_WIDTH = 6;
  localparam int DATA_WIDTH = 10;
  localparam logic [3:0] OP_LOAD = 4'd0, OP_STORE = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_MUL = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd6, OP_JZ = 4'd7, OP_NOP = 4'd8, OP_HALT = 4'd9;
  typedef enum logic [2:0] {IDLE, RECV_CNT, RECV_HI, RECV_LO, RUN, ERROR} ld_state_e;
endpackage

// File: rtl/fbcpu_mem_loader_if.sv
// fbcpu_mem_loader_if: host byte stream plus the core's memory port.
interface fbcpu_mem_loader_if #(
  parameter int AW = fbcpu_pkg::ADDRESS_WIDTH,
  parameter int DW = fbcpu_pkg::DATA_WIDTH
);
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic [AW-1:0] MAR;
  logic RAMWr;
  logic [DW-1:0] MDRIn;
  logic [DW-1:0] MDROut;
  modport master (output rx_data, rx_valid, MAR, RAMWr, MDRIn, input rx_ready, MDROut);
  modport slave (input rx_data, rx_valid, MAR, RAMWr, MDRIn, output rx_ready, MDROut);
endinterface

// File: rtl/fbcpu_ram.sv
// fbcpu_ram: sync-write, read-first sync-read RAM; read data clears on reset.
module fbcpu_ram #(
  parameter int AW = 6,
  parameter int DW = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [1 << AW];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  always_ff @(posedge clk) begin
    rdata_o <= rst ? '0 : mem_q[raddr_i];
  end
endmodule

// File: rtl/fbcpu_mem_loader.sv
// fbcpu_mem_loader: program RAM with a byte-stream boot loader that holds the core in reset until a load completes.
module fbcpu_mem_loader #(
  parameter int ADDRESS_WIDTH = fbcpu_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH = fbcpu_pkg::DATA_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic load_start,
  output logic cpu_rst,
  output logic load_done,
  output logic load_err,
  fbcpu_mem_loader_if.slave bus
);
  import fbcpu_pkg::*;
  localparam int HW = DATA_WIDTH - 8;
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  ld_state_e state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] waddr_q, last_q, ram_waddr;
  logic [HW-1:0] hi_q;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [6:0] n;
  logic cpu_rst_q, load_done_q, load_err_q, acc, cnt_ok, hi_ok, ram_we;
  assign n = bus.rx_data[6:0];
  assign bus.rx_ready = state_q inside {RECV_CNT, RECV_HI, RECV_LO};
  assign acc = bus.rx_valid && bus.rx_ready;
  assign cnt_ok = !bus.rx_data[7] && n != 7'd0 && int'(n) <= DEPTH;
  assign hi_ok = (bus.rx_data >> HW) == 8'd0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN, ERROR: state_d = load_start ? RECV_CNT : state_q;
      RECV_CNT: state_d = acc ? (cnt_ok ? RECV_HI : ERROR) : state_q;
      RECV_HI: state_d = acc ? (hi_ok ? RECV_LO : ERROR) : state_q;
      RECV_LO: state_d = acc ? (waddr_q == last_q ? RUN : RECV_HI) : state_q;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      waddr_q <= '0;
      last_q <= '0;
      hi_q <= '0;
      cpu_rst_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cpu_rst_q <= state_d != RUN;
      load_done_q <= state_d == RUN;
      load_err_q <= state_d == ERROR;
      if (acc && state_q == RECV_CNT) begin
        last_q <= ADDRESS_WIDTH'(n - 7'd1);
        waddr_q <= '0;
      end
      if (acc && state_q == RECV_HI) hi_q <= bus.rx_data[HW-1:0];
      if (acc && state_q == RECV_LO && waddr_q != last_q) waddr_q <= waddr_q + ADDRESS_WIDTH'(1);
    end
  end
  // The core owns the write port only while it runs; otherwise the loader does.
  assign ram_we = !rst && (state_q == RUN ? bus.RAMWr : (state_q == RECV_LO && acc));
  assign ram_waddr = state_q == RUN ? bus.MAR : waddr_q;
  assign ram_wdata = state_q == RUN ? bus.MDRIn : {hi_q, bus.rx_data};
  fbcpu_ram #(.AW(ADDRESS_WIDTH), .DW(DATA_WIDTH)) u_ram (
    .clk(clk),
    .rst(rst),
    .we_i(ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(bus.MAR),
    .rdata_o(bus.MDROut)
  );
  assign cpu_rst = cpu_rst_q;
  assign load_done = load_done_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_fbcpu_mem_loader.sv
// tb_fbcpu_mem_loader: directed bench with a read-data scoreboard and a shadow RAM model.
module tb_fbcpu_mem_loader;
  localparam int AW = 6;
  localparam int DW = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_start = 1'b0;
  logic cpu_rst, load_done, load_err;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [64];
  logic [DW-1:0] prog [64];
  logic [DW-1:0] exp_q [$];
  fbcpu_mem_loader_if #(.AW(AW), .DW(DW)) bus ();
  fbcpu_mem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .load_start(load_start),
    .cpu_rst(cpu_rst),
    .load_done(load_done),
    .load_err(load_err),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.rx_valid = 1'b0;
    repeat (gap) tick();
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 20) begin
      tick();
      n++;
    end
    chk("rx_ready_wait", bus.rx_ready, 1);
    tick();
    bus.rx_valid = 1'b0;
  endtask

  function automatic int gap_of(input int gmax);
    return gmax == 0 ? 0 : int'($urandom_range(gmax, 0));
  endfunction

  task automatic load_prog(input int n, input int gmax);
    send_byte(8'(n), gap_of(gmax));
    for (int i = 0; i < n; i++) begin
      send_byte(8'(prog[i] >> 8), gap_of(gmax));
      if (i == n - 1) chk("cpu_rst_before_last", cpu_rst, 1);
      send_byte(prog[i][7:0], gap_of(gmax));
    end
    chk("cpu_rst_after_last", cpu_rst, 0);
    chk("load_done", load_done, 1);
    chk("rx_ready_run", bus.rx_ready, 0);
    for (int i = 0; i < n; i++) model[i] = prog[i];
  endtask

  task automatic rd(input int a);
    bus.MAR = AW'(a);
    bus.RAMWr = 1'b0;
    exp_q.push_back(model[a]);
    tick();
    chk($sformatf("rd_%0d", a), bus.MDROut, exp_q.pop_front());
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input bit applies, input bit chk_old);
    bus.MAR = AW'(a);
    bus.MDRIn = d;
    bus.RAMWr = 1'b1;
    if (chk_old) exp_q.push_back(model[a]);
    tick();
    bus.RAMWr = 1'b0;
    if (chk_old) chk($sformatf("rdw_old_%0d", a), bus.MDROut, exp_q.pop_front());
    if (applies) model[a] = d;
  endtask

  task automatic expect_err(input string tag);
    chk({tag, "_err"}, load_err, 1);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_ready"}, bus.rx_ready, 0);
  endtask

  initial begin
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    bus.MAR = '0;
    bus.RAMWr = 1'b0;
    bus.MDRIn = '0;
    tick();
    tick();
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_ready", bus.rx_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_mdrout", bus.MDROut, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", bus.rx_ready, 0);
    chk("idle_cpu_rst", cpu_rst, 1);
    // basic load
    prog[0] = 10'h005; prog[1] = 10'h107; prog[2] = 10'h240;
    start();
    load_prog(3, 0);
    rd(0); rd(1); rd(2);
    // same stream with random valid gaps, entered from RUN
    start();
    chk("reload_cpu_rst", cpu_rst, 1);
    chk("reload_done", load_done, 0);
    load_prog(3, 5);
    rd(0); rd(1); rd(2);
    // malformed streams
    start();
    send_byte(8'h00, 0);
    expect_err("cnt00");
    start();
    chk("err_cleared", load_err, 0);
    send_byte(8'h41, 0);
    expect_err("cnt41");
    start();
    send_byte(8'h80, 0);
    expect_err("cnt80");
    start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    expect_err("hi04");
    rd(0); rd(1);
    start();
    prog[0] = 10'h3C1; prog[1] = 10'h02A; prog[2] = 10'h240;
    load_prog(3, 2);
    chk("recover_err", load_err, 0);
    rd(0); rd(1);
    // core access while running
    rd(2);
    wr(5, 10'h3FF, 1'b1, 1'b0);
    rd(5);
    wr(5, 10'h155, 1'b1, 1'b1);
    rd(5);
    // core write ignored outside RUN, then reset mid-load
    start();
    wr(0, 10'h3FF, 1'b0, 1'b1);
    rd(0);
    send_byte(8'h03, 0);
    send_byte(8'h02, 1);
    send_byte(8'hAA, 0);
    send_byte(8'h01, 2);
    send_byte(8'h55, 0);
    model[0] = 10'h2AA;
    model[1] = 10'h155;
    rst = 1'b1;
    tick();
    chk("midrst_cpu_rst", cpu_rst, 1);
    chk("midrst_ready", bus.rx_ready, 0);
    chk("midrst_done", load_done, 0);
    chk("midrst_mdrout", bus.MDROut, 0);
    rst = 1'b0;
    tick();
    chk("midrst_idle_ready", bus.rx_ready, 0);
    rd(0); rd(1); rd(2); rd(5);
    // single-word load, then full-depth reload from RUN
    prog[0] = 10'h001;
    start();
    load_prog(1, 0);
    rd(0);
    start();
    chk("full_cpu_rst", cpu_rst, 1);
    chk("full_done", load_done, 0);
    for (int i = 0; i < 64; i++) prog[i] = DW'($urandom);
    load_prog(64, 1);
    rd(63); rd(0); rd(31); rd(62);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
